// File: rtl/ivl_uvm_ovl_window_gen.sv
// Purpose : OVL window-protocol stimulus generator (start_event / test_expr / end_event).
// Latency : start_event 1 cycle after an accepted go; end_event win_len+1 cycles after start_event.
// Backpr. : go is accepted only when idle; a go seen while busy is dropped, never queued.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   go                  window request, sampled only when the block can accept it
//   win_len             number of HOLD cycles between start and end (latched on accept)
//   drop_en, drop_at    one-cycle test_expr drop at HOLD index drop_at (latched on accept)
//   busy                high in every state except IDLE
//   done                one-cycle pulse coincident with end_event
//   start_event, test_expr, end_event   window protocol outputs (all registered)
//   window_count        completed windows, wraps silently
//
// Build option: define IVL_UVM_OVL_WINDOW_GEN_BACK2BACK_EN to accept a go during the
// END cycle and skip GAP, so a new start_event follows end_event directly.
module ivl_uvm_ovl_window_gen #(
    parameter int LEN_W      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [LEN_W-1:0] win_len,
    input  logic             drop_en,
    input  logic [LEN_W-1:0] drop_at,
    output logic             busy,
    output logic             done,
    output logic             start_event,
    output logic             test_expr,
    output logic             end_event,
    output logic [CNT_W-1:0] window_count
);

    // Counter holds 0..GAP_CYCLES-1; at least one bit even for GAP_CYCLES of 0 or 1.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        HOLD  = 3'd2,
        END   = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic             drop_en_q;
    logic [LEN_W-1:0] drop_at_q;
    logic [LEN_W-1:0] hold_k;
    logic [GAP_W-1:0] gap_cnt;

    // All outputs are computed for the state being entered, so they are registered
    // alongside the state and line up with it cycle for cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            len_q        <= '0;
            drop_en_q    <= 1'b0;
            drop_at_q    <= '0;
            hold_k       <= '0;
            gap_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            start_event  <= 1'b0;
            test_expr    <= 1'b0;
            end_event    <= 1'b0;
            window_count <= '0;
        end else begin
            // Pulses default low; each branch raises what the next state needs.
            done        <= 1'b0;
            start_event <= 1'b0;
            end_event   <= 1'b0;
            test_expr   <= 1'b0;

            case (state)
                IDLE: begin
                    if (go) begin
                        len_q       <= win_len;
                        drop_en_q   <= drop_en;
                        drop_at_q   <= drop_at;
                        state       <= START;
                        busy        <= 1'b1;
                        start_event <= 1'b1;
                        test_expr   <= 1'b1;
                    end
                end

                START: begin
                    if (len_q != '0) begin
                        state     <= HOLD;
                        hold_k    <= '0;
                        test_expr <= !(drop_en_q && (drop_at_q == '0));
                    end else begin
                        state        <= END;
                        end_event    <= 1'b1;
                        done         <= 1'b1;
                        test_expr    <= 1'b1;
                        window_count <= window_count + CNT_W'(1);
                    end
                end

                HOLD: begin
                    if (hold_k == (len_q - LEN_W'(1))) begin
                        state        <= END;
                        end_event    <= 1'b1;
                        done         <= 1'b1;
                        test_expr    <= 1'b1;
                        window_count <= window_count + CNT_W'(1);
                    end else begin
                        // Look one index ahead: test_expr shown next cycle belongs to k+1.
                        // drop_at >= win_len can never equal a valid index, so no drop.
                        hold_k    <= hold_k + LEN_W'(1);
                        test_expr <= !(drop_en_q && (drop_at_q == (hold_k + LEN_W'(1))));
                    end
                end

                END: begin
`ifdef IVL_UVM_OVL_WINDOW_GEN_BACK2BACK_EN
                    if (go) begin
                        len_q       <= win_len;
                        drop_en_q   <= drop_en;
                        drop_at_q   <= drop_at;
                        state       <= START;
                        start_event <= 1'b1;
                        test_expr   <= 1'b1;
                    end else
`endif
                    if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
